// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM macro among NREQ requesters.
// One access is granted per cycle in round-robin order. The winning
// address, write data and active-low write enable are registered onto the
// macro pins. Read data comes back to the issuing requester two cycles
// after the accept edge, qualified by a one-hot rvalid_o.
//
// Optional feature: define ARB_BURST_EN so that the current owner can keep
// the grant for up to MAX_BURST consecutive accesses. Without the macro,
// arbitration is strict per-access round-robin and there is no burst
// counter.
//
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   req_i      : per-requester access request
//   we_i       : per-requester write (1) / read (0)
//   addr_i     : packed addresses, requester i at [i*AW +: AW]
//   wdata_i    : packed write data, requester i at [i*DW +: DW]
//   gnt_o      : one-hot combinational grant; accept = req_i[i] & gnt_o[i]
//   rvalid_o   : one-hot read-data valid, one cycle per read
//   rdata_o    : shared read data, holds its value while rvalid_o = 0
//   sram_a     : registered SRAM address
//   sram_di    : registered SRAM write data
//   sram_we_b  : registered SRAM write enable, active-low
//   sram_do    : SRAM data output
module sram_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*DW-1:0]   wdata_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic [AW-1:0]        sram_a,
    output logic [DW-1:0]        sram_di,
    output logic                 sram_we_b,
    input  logic [DW-1:0]        sram_do
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject parameter values the arbiter is not built for.
    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("sram_port_arbiter: NREQ must be in 2..8");
        end
        if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
            $error("sram_port_arbiter: MAX_BURST must be in 1..16");
        end
    endgenerate

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
    endfunction

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   sram_a_q, sram_a_d;
    logic [DW-1:0]   sram_di_q, sram_di_d;
    logic            sram_we_b_q, sram_we_b_d;
    logic            tag1_vld_q, tag1_vld_d;
    logic [PW-1:0]   tag1_id_q, tag1_id_d;
    logic            tag2_vld_q, tag2_vld_d;
    logic [PW-1:0]   tag2_id_q, tag2_id_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] gnt;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] run;
`endif

    // Round-robin search: walk from the pointer, wrapping modulo NREQ, and
    // take the first requester that is asserting req_i. The grant is held
    // low during reset so nothing can be accepted on a reset edge.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any && req_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any && rst_n) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Issue stage and read-tag pipeline. Idle cycles force a read on the
    // macro so a write is never repeated, while address and data hold.
    // Only reads enter the tag pipeline; its second stage lines up with
    // sram_do carrying the data sampled by the macro.
    always_comb begin
        sram_a_d    = sram_a_q;
        sram_di_d   = sram_di_q;
        sram_we_b_d = 1'b1;
        tag1_vld_d  = 1'b0;
        tag1_id_d   = gnt_idx;
        tag2_vld_d  = tag1_vld_q;
        tag2_id_d   = tag1_id_q;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        if (gnt_any) begin
            sram_a_d    = addr_i[int'(gnt_idx)*AW +: AW];
            sram_di_d   = wdata_i[int'(gnt_idx)*DW +: DW];
            sram_we_b_d = ~we_i[gnt_idx];
            tag1_vld_d  = ~we_i[gnt_idx];
        end
        if (tag2_vld_q) begin
            rvalid_d[tag2_id_q] = 1'b1;
            rdata_d             = sram_do;
        end
    end

`ifdef ARB_BURST_EN
    // Burst ownership: the pointer parks on the owner while it keeps being
    // accepted. The owner is handed off after MAX_BURST accepts, or as soon
    // as it goes quiet. A grant to anyone else starts a new count for that
    // requester, which becomes the new owner.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        run   = '0;
        if (gnt_any) begin
            run = (gnt_idx == ptr_q) ? cnt_q + CW'(1) : CW'(1);
            if (run >= CW'(MAX_BURST)) begin
                ptr_d = next_idx(gnt_idx);
                cnt_d = '0;
            end else begin
                ptr_d = gnt_idx;
                cnt_d = run;
            end
        end else if (cnt_q != '0) begin
            ptr_d = next_idx(ptr_q);
            cnt_d = '0;
        end
    end
`else
    // Strict round-robin: the pointer moves just past each accepted
    // requester and holds when nothing is accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = next_idx(gnt_idx);
        end
    end
`endif

    // State registers. Reset clears in-flight read tags so no stale rvalid
    // can appear after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            sram_a_q    <= '0;
            sram_di_q   <= '0;
            sram_we_b_q <= 1'b1;
            tag1_vld_q  <= 1'b0;
            tag1_id_q   <= '0;
            tag2_vld_q  <= 1'b0;
            tag2_id_q   <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
`ifdef ARB_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            sram_a_q    <= sram_a_d;
            sram_di_q   <= sram_di_d;
            sram_we_b_q <= sram_we_b_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_id_q   <= tag1_id_d;
            tag2_vld_q  <= tag2_vld_d;
            tag2_id_q   <= tag2_id_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
`ifdef ARB_BURST_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt_o     = gnt;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign sram_a    = sram_a_q;
    assign sram_di   = sram_di_q;
    assign sram_we_b = sram_we_b_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//
// Self-checking bench for sram_port_arbiter. A behavioural SRAM sits on the
// macro pins. Expected behaviour comes from a transaction-level reference
// model: a rotating priority pointer, a reference memory updated at accept
// time, and a queue of pending read returns keyed by due cycle. Directed
// scenarios run first, then randomized traffic with random withdrawals
// and resets. Define ARB_BURST_EN to check the burst-ownership build.
module tb_sram_port_arbiter;

    localparam int NREQ      = 3;
    localparam int AW        = 12;
    localparam int DW        = 16;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_i = '0;
    logic [NREQ-1:0]     we_i = '0;
    logic [NREQ*AW-1:0]  addr_i = '0;
    logic [NREQ*DW-1:0]  wdata_i = '0;
    logic [NREQ-1:0]     gnt_o;
    logic [NREQ-1:0]     rvalid_o;
    logic [DW-1:0]       rdata_o;
    logic [AW-1:0]       sram_a;
    logic [DW-1:0]       sram_di;
    logic                sram_we_b;
    logic [DW-1:0]       sram_do;

    sram_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .sram_a(sram_a),
        .sram_di(sram_di), .sram_we_b(sram_we_b), .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous SRAM: write or read on each edge.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_we_b) sram_mem[sram_a] <= sram_di;
        else            sram_do <= sram_mem[sram_a];
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } read_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    read_t           rd_q[$];
    logic [DW-1:0]   ref_mem [int];
    int              m_ptr = 0;
    int              m_run = 0;
    int              cyc = 0;
    logic [AW-1:0]   e_a;
    logic [DW-1:0]   e_di;
    logic            e_web;
    logic [NREQ-1:0] e_rvalid;
    logic [DW-1:0]   e_rdata;
    logic [NREQ-1:0] obs_gnt;

    // Pending request table, one entry per requester
    logic            p_req  [NREQ];
    logic            p_we   [NREQ];
    logic [AW-1:0]   p_addr [NREQ];
    logic [DW-1:0]   p_data [NREQ];

    logic [AW-1:0] pool [16] = '{12'h000, 12'h001, 12'h002, 12'h003,
                                 12'h0A5, 12'hFFF, 12'h800, 12'h7FF,
                                 12'h010, 12'h123, 12'hABC, 12'hFFE,
                                 12'h555, 12'hAAA, 12'h3C3, 12'hF0F};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int pickGrant(input logic [NREQ-1:0] req);
        for (int k = 0; k < NREQ; k++) begin
            int c = (m_ptr + k) % NREQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_ptr    = 0;
        m_run    = 0;
        e_a      = '0;
        e_di     = '0;
        e_web    = 1'b1;
        e_rvalid = '0;
        e_rdata  = '0;
        rd_q.delete();
    endtask

    task automatic setReq(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        p_req[i]  = 1'b1;
        p_we[i]   = we;
        p_addr[i] = a;
        p_data[i] = d;
    endtask

    // One clock cycle: drive the pending table, check the combinational
    // grant, advance the model across the edge, check registered outputs.
    task automatic applyStimulus(input logic rst, output int acc);
        logic [NREQ-1:0]    req, we, exp_gnt;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] wd;
        read_t              r;
        int                 g;
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = p_req[i];
            we[i]              = p_we[i];
            addr[i*AW +: AW]   = p_addr[i];
            wd[i*DW +: DW]     = p_data[i];
        end
        @(negedge clk);
        rst_n   = rst;
        req_i   = req;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wd;
        #1;
        g = rst ? pickGrant(req) : -1;
        exp_gnt = '0;
        if (g >= 0) exp_gnt[g] = 1'b1;
        obs_gnt = gnt_o;
        checkOutput("gnt", 32'(gnt_o), 32'(exp_gnt));
        @(posedge clk);
        cyc++;
        acc = g;
        if (!rst) begin
            modelReset();
        end else begin
            e_rvalid = '0;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                e_rvalid[rd_q[0].id] = 1'b1;
                e_rdata = rd_q[0].data;
                void'(rd_q.pop_front());
            end
            if (g >= 0) begin
                e_a   = p_addr[g];
                e_di  = p_data[g];
                e_web = ~p_we[g];
                if (p_we[g]) begin
                    ref_mem[int'(p_addr[g])] = p_data[g];
                end else begin
                    r.due  = cyc + 2;
                    r.id   = g;
                    r.data = ref_mem[int'(p_addr[g])];
                    rd_q.push_back(r);
                end
`ifdef ARB_BURST_EN
                m_run = (g == m_ptr) ? m_run + 1 : 1;
                if (m_run >= MAX_BURST) begin
                    m_ptr = (g + 1) % NREQ;
                    m_run = 0;
                end else begin
                    m_ptr = g;
                end
`else
                m_ptr = (g + 1) % NREQ;
`endif
            end else begin
                e_web = 1'b1;
`ifdef ARB_BURST_EN
                if (m_run != 0) begin
                    m_ptr = (m_ptr + 1) % NREQ;
                    m_run = 0;
                end
`endif
            end
        end
        #1;
        checkOutput("sram_a",    32'(sram_a),    32'(e_a));
        checkOutput("sram_di",   32'(sram_di),   32'(e_di));
        checkOutput("sram_we_b", 32'(sram_we_b), 32'(e_web));
        checkOutput("rvalid",    32'(rvalid_o),  32'(e_rvalid));
        checkOutput("rdata",     32'(rdata_o),   32'(e_rdata));
    endtask

    task automatic driveCycle(input logic rst);
        int acc;
        applyStimulus(rst, acc);
        if (acc >= 0) p_req[acc] = 1'b0;
    endtask

    function automatic int pendingCount();
        int n = 0;
        for (int i = 0; i < NREQ; i++) if (p_req[i]) n++;
        return n;
    endfunction

    task automatic runUntilIdle(input int budget);
        int n = 0;
        while (pendingCount() > 0 && n < budget) begin
            driveCycle(1'b1);
            n++;
        end
        for (int k = 0; k < 3; k++) driveCycle(1'b1);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        modelReset();

        // Reset held 3 cycles with every requester asking to write
        $display("[TB] reset with all requesters active");
        setReq(0, 1'b1, 12'h001, 16'h1111);
        setReq(1, 1'b1, 12'h002, 16'h2222);
        setReq(2, 1'b1, 12'h003, 16'h3333);
        for (int k = 0; k < 3; k++) driveCycle(1'b0);
        driveCycle(1'b1);
        checkOutput("gnt_after_reset", 32'(obs_gnt), 32'h1);
        runUntilIdle(10);

        // Single write then read by requester 1
        $display("[TB] single write/read by requester 1");
        setReq(1, 1'b1, 12'h0A5, 16'h1234);
        driveCycle(1'b1);
        checkOutput("wr_web_low", 32'(sram_we_b), 32'h0);
        driveCycle(1'b1);
        checkOutput("wr_web_once", 32'(sram_we_b), 32'h1);
        setReq(1, 1'b0, 12'h0A5, 16'h0000);
        driveCycle(1'b1);
        driveCycle(1'b1);
        checkOutput("rd_early_rvalid", 32'(rvalid_o), 32'h0);
        driveCycle(1'b1);
        checkOutput("rd_rvalid", 32'(rvalid_o), 32'h2);
        checkOutput("rd_data", 32'(rdata_o), 32'h1234);
        driveCycle(1'b1);
        checkOutput("rd_hold", 32'(rdata_o), 32'h1234);

        // All three reading continuously
        $display("[TB] continuous reads from all requesters");
        for (int n = 0; n < 9; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_req[i]) setReq(i, 1'b0, AW'(i + 1), '0);
            driveCycle(1'b1);
        end
        runUntilIdle(10);

        // Reset with a read in flight at T+1
        $display("[TB] reset with read in flight");
        setReq(0, 1'b0, 12'h002, '0);
        driveCycle(1'b1);
        driveCycle(1'b0);
        driveCycle(1'b1);
        checkOutput("no_rvalid_after_reset", 32'(rvalid_o), 32'h0);

        // Withdrawal by requester 2 while requester 0 wins
        $display("[TB] request withdrawal");
        setReq(0, 1'b0, 12'h002, '0);
        setReq(2, 1'b0, 12'h003, '0);
        driveCycle(1'b1);
        p_req[2] = 1'b0;
        driveCycle(1'b1);
        driveCycle(1'b1);
        checkOutput("post_reset_rvalid", 32'(rvalid_o), 32'h1);
        checkOutput("post_reset_rdata", 32'(rdata_o), 32'h2222);
        setReq(1, 1'b0, 12'h001, '0);
        setReq(2, 1'b0, 12'h003, '0);
        driveCycle(1'b1);
        checkOutput("ptr_after_withdraw", 32'(obs_gnt), 32'h2);
        runUntilIdle(10);

        // Requesters 0 and 1 continuously requesting from pointer 0
        $display("[TB] two-requester grant pattern");
        driveCycle(1'b0);
        for (int n = 0; n < 10; n++) begin
            int who;
`ifdef ARB_BURST_EN
            who = (n / MAX_BURST) % 2;
`else
            who = n % 2;
`endif
            for (int i = 0; i < 2; i++)
                if (!p_req[i]) setReq(i, 1'b0, AW'(i + 1), '0);
            driveCycle(1'b1);
            checkOutput("pair_seq", 32'(obs_gnt), 32'(1 << who));
        end
        runUntilIdle(10);

        // Initialise the address pool, then randomized traffic
        $display("[TB] randomized traffic");
        for (int k = 0; k < 16; k++) begin
            setReq(k % NREQ, 1'b1, pool[k], DW'($urandom));
            runUntilIdle(10);
        end
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (p_req[i]) begin
                    if ($urandom_range(15) == 0) p_req[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    setReq(i, 1'($urandom_range(1)), pool[$urandom_range(15)], DW'($urandom));
                end
            end
            driveCycle(($urandom_range(79) != 0));
        end
        runUntilIdle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
